dest_reg_scoreboard: RTL and testbench

- Consumer of the 5-bit destination register number chosen by the register-destination mux (rt vs rd) in the datapath.
- Carries each issued destination down a fixed-depth shift pipeline to the register-file write port.
- Tracks which architectural registers have writes in flight and raises a read-after-write stall for the issuing instruction.
- Sits between decode/issue and the register-file writeback port.

---
 rtl/dest_reg_scoreboard.sv | 132 +++++++++++++
 tb/tb_dest_reg_scoreboard.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dest_reg_scoreboard.sv
// dest_reg_scoreboard
//
// Carries the destination register picked by the rt/rd destination mux down a
// fixed-depth shift pipeline to the register-file write port, and raises a
// read-after-write stall when the issuing instruction reads a register that
// still has a write in flight.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   issue_valid  instruction presented for issue this cycle
//   issue_dest   destination register of the issuing instruction
//   issue_wen    issuing instruction writes a register
//   rs_addr      source register A of the issuing instruction
//   rs_used      issuing instruction reads rs
//   rt_addr      source register B of the issuing instruction
//   rt_used      issuing instruction reads rt
//   flush        synchronous squash of all younger in-flight entries
//   stall        hazard, issue not accepted this cycle (combinational)
//   wb_valid     writeback stage holds an entry (registered)
//   wb_wen       register-file write enable (registered)
//   wb_dest      register-file write address (registered)
//   pending_cnt  in-flight entries that will write a nonzero register

module dest_reg_scoreboard #(
    parameter int DEPTH = 3,
    parameter int REG_W = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    input  logic [REG_W-1:0]             issue_dest,
    input  logic                         issue_wen,
    input  logic [REG_W-1:0]             rs_addr,
    input  logic                         rs_used,
    input  logic [REG_W-1:0]             rt_addr,
    input  logic                         rt_used,
    input  logic                         flush,
    output logic                         stall,
    output logic                         wb_valid,
    output logic                         wb_wen,
    output logic [REG_W-1:0]             wb_dest,
    output logic [$clog2(DEPTH+1)-1:0]   pending_cnt
);

    localparam int CNT_W = $clog2(DEPTH+1);

    // Stage 0 is the youngest entry; stage DEPTH-1 drives the write port.
    logic [DEPTH-1:0] stg_valid;
    logic [DEPTH-1:0] stg_wen;
    logic [REG_W-1:0] stg_dest [DEPTH];

    logic [DEPTH-1:0] nxt_valid;
    logic [DEPTH-1:0] nxt_wen;
    logic [REG_W-1:0] nxt_dest [DEPTH];
    logic [CNT_W-1:0] nxt_cnt;

    logic rs_busy;
    logic rt_busy;
    logic accept;

    // Busy lookup over every stage, including the one writing back this
    // cycle: there is no bypass, so that register is still unreadable.
    // Register 0 is hardwired, so entries targeting it never block anyone.
    always_comb begin
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (stg_valid[i] && stg_wen[i] && (stg_dest[i] != '0)) begin
                if (stg_dest[i] == rs_addr) rs_busy = 1'b1;
                if (stg_dest[i] == rt_addr) rt_busy = 1'b1;
            end
        end
    end

    // Only in-flight entries are compared, so an instruction reading its own
    // destination does not stall on itself.
    assign stall  = issue_valid & ((rs_used & rs_busy) | (rt_used & rt_busy));
    assign accept = issue_valid & ~stall;

    // Next pipeline contents. The pipeline always advances; a stalled or
    // absent issue becomes an all-zero bubble. On flush every younger entry
    // is dropped, while the current writeback entry still leaves normally.
    always_comb begin
        nxt_valid = '0;
        nxt_wen   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            nxt_dest[i] = '0;
        end
        if (!flush) begin
            nxt_valid[0] = accept;
            nxt_wen[0]   = accept & issue_wen;
            nxt_dest[0]  = (accept && issue_wen) ? issue_dest : '0;
            for (int i = 1; i < DEPTH; i++) begin
                nxt_valid[i] = stg_valid[i-1];
                nxt_wen[i]   = stg_wen[i-1];
                nxt_dest[i]  = stg_dest[i-1];
            end
        end
        nxt_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (nxt_valid[i] && nxt_wen[i] && (nxt_dest[i] != '0)) begin
                nxt_cnt = nxt_cnt + CNT_W'(1);
            end
        end
    end

    // State register. Reset drops every in-flight entry at once, which also
    // clears the stall and suppresses any pending writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid   <= '0;
            stg_wen     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stg_dest[i] <= '0;
            end
            pending_cnt <= '0;
        end else begin
            stg_valid   <= nxt_valid;
            stg_wen     <= nxt_wen;
            for (int i = 0; i < DEPTH; i++) begin
                stg_dest[i] <= nxt_dest[i];
            end
            pending_cnt <= nxt_cnt;
        end
    end

    assign wb_valid = stg_valid[DEPTH-1];
    assign wb_wen   = stg_wen[DEPTH-1];
    assign wb_dest  = stg_dest[DEPTH-1];

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// tb_dest_reg_scoreboard
//
// Self-checking bench for dest_reg_scoreboard (DEPTH=3). The reference model
// is a list of in-flight instructions, each tagged with its age in cycles
// since issue; the writeback entry is the one of age DEPTH-1.

module tb_dest_reg_scoreboard;

    localparam int DEPTH = 3;
    localparam int REG_W = 5;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             clk;
    logic             rst_n;
    logic             issue_valid;
    logic [REG_W-1:0] issue_dest;
    logic             issue_wen;
    logic [REG_W-1:0] rs_addr;
    logic             rs_used;
    logic [REG_W-1:0] rt_addr;
    logic             rt_used;
    logic             flush;
    logic             stall;
    logic             wb_valid;
    logic             wb_wen;
    logic [REG_W-1:0] wb_dest;
    logic [CNT_W-1:0] pending_cnt;

    int checks;
    int failures;

    logic obs_stall;
    logic exp_stall;

    typedef struct packed {
        logic             wen;
        logic [REG_W-1:0] dest;
        logic [7:0]       age;
    } ent_t;

    ent_t inflight[$];

    dest_reg_scoreboard #(.DEPTH(DEPTH), .REG_W(REG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_wen   (issue_wen),
        .rs_addr     (rs_addr),
        .rs_used     (rs_used),
        .rt_addr     (rt_addr),
        .rt_used     (rt_used),
        .flush       (flush),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_wen      (wb_wen),
        .wb_dest     (wb_dest),
        .pending_cnt (pending_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model queries
    function automatic bit m_busy(logic [REG_W-1:0] r);
        bit b = 1'b0;
        foreach (inflight[k]) begin
            if (inflight[k].wen && inflight[k].dest == r && r != 0) b = 1'b1;
        end
        return b;
    endfunction

    function automatic logic m_wb_valid();
        foreach (inflight[k]) if (inflight[k].age == DEPTH-1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_wb_wen();
        foreach (inflight[k]) if (inflight[k].age == DEPTH-1) return inflight[k].wen;
        return 1'b0;
    endfunction

    function automatic logic [REG_W-1:0] m_wb_dest();
        foreach (inflight[k]) if (inflight[k].age == DEPTH-1) return inflight[k].dest;
        return '0;
    endfunction

    function automatic int m_pending();
        int n = 0;
        foreach (inflight[k]) if (inflight[k].wen && inflight[k].dest != 0) n++;
        return n;
    endfunction

    // Drives one cycle (entered and left at posedge+1): samples stall at the
    // negedge, then advances the model across the posedge.
    task automatic drive_cycle(input logic iv, input logic [REG_W-1:0] d, input logic w,
                               input logic [REG_W-1:0] rs, input logic rsu,
                               input logic [REG_W-1:0] rt, input logic rtu,
                               input logic fl);
        bit   acc;
        ent_t e;
        issue_valid = iv;
        issue_dest  = d;
        issue_wen   = w;
        rs_addr     = rs;
        rs_used     = rsu;
        rt_addr     = rt;
        rt_used     = rtu;
        flush       = fl;
        @(negedge clk);
        obs_stall = stall;
        exp_stall = iv && ((rsu && m_busy(rs)) || (rtu && m_busy(rt)));
        acc = iv && !exp_stall;
        @(posedge clk);
        foreach (inflight[k]) inflight[k].age = inflight[k].age + 8'd1;
        for (int k = inflight.size() - 1; k >= 0; k--) begin
            if (inflight[k].age >= DEPTH) inflight.delete(k);
        end
        if (fl) begin
            inflight.delete();
        end else if (acc) begin
            e.wen  = w;
            e.dest = w ? d : '0;
            e.age  = 8'd0;
            inflight.push_back(e);
        end
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) drive_cycle(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        issue_valid = 1'b1;
        issue_dest  = 5'd7;
        issue_wen   = 1'b1;
        rs_addr     = 5'd7;
        rs_used     = 1'b1;
        rt_addr     = '0;
        rt_used     = 1'b0;
        flush       = 1'b0;
        inflight.delete();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_valid: got %b want 0", wb_valid); end
        checks++;
        if (pending_cnt !== '0) begin failures++; $display("[TB] FAIL reset_pending: got %0d want 0", pending_cnt); end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
        rst_n = 1'b1;
        drive_cycle(1'b1, 5'd7, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (pending_cnt !== CNT_W'(1)) begin failures++; $display("[TB] FAIL reset_first_pending: got %0d want 1", pending_cnt); end
        idle_cycles(1);
        checks++;
        if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_early_wb: got %b want 0", wb_valid); end
        idle_cycles(1);
        checks++;
        if (wb_valid !== 1'b1 || wb_wen !== 1'b1 || wb_dest !== 5'd7) begin
            failures++;
            $display("[TB] FAIL reset_first_wb: got v=%b w=%b d=%0d want v=1 w=1 d=7", wb_valid, wb_wen, wb_dest);
        end
    endtask

    task automatic test_raw_hazard();
        int  nstall = 0;
        int  nwb5   = 0;
        bit  done   = 1'b0;
        idle_cycles(DEPTH);
        drive_cycle(1'b1, 5'd5, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 8 && !done; c++) begin
            drive_cycle(1'b1, 5'd9, 1'b1, 5'd5, 1'b1, '0, 1'b0, 1'b0);
            checks++;
            if (obs_stall !== exp_stall) begin failures++; $display("[TB] FAIL raw_stall c=%0d: got %b want %b", c, obs_stall, exp_stall); end
            checks++;
            if (wb_valid !== m_wb_valid() || wb_wen !== m_wb_wen()) begin
                failures++;
                $display("[TB] FAIL raw_wb c=%0d: got v=%b w=%b want v=%b w=%b", c, wb_valid, wb_wen, m_wb_valid(), m_wb_wen());
            end
            if (obs_stall === 1'b1) nstall++; else done = 1'b1;
            if (wb_valid === 1'b1 && wb_wen === 1'b1 && wb_dest === 5'd5) nwb5++;
        end
        checks++;
        if (!done) begin failures++; $display("[TB] FAIL raw_timeout: got stall stuck high want release"); end
        checks++;
        if (nstall != 3) begin failures++; $display("[TB] FAIL raw_stall_cycles: got %0d want 3", nstall); end
        checks++;
        if (nwb5 != 1) begin failures++; $display("[TB] FAIL raw_wb5_cycles: got %0d want 1", nwb5); end
    endtask

    task automatic test_reg_zero();
        idle_cycles(DEPTH);
        drive_cycle(1'b1, 5'd0, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd0, 1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b0);
        checks++;
        if (obs_stall !== 1'b0) begin failures++; $display("[TB] FAIL reg0_stall: got %b want 0", obs_stall); end
        checks++;
        if (pending_cnt !== '0) begin failures++; $display("[TB] FAIL reg0_pending: got %0d want 0", pending_cnt); end
        idle_cycles(1);
        checks++;
        if (wb_valid !== 1'b1 || wb_wen !== 1'b1 || wb_dest !== 5'd0) begin
            failures++;
            $display("[TB] FAIL reg0_wb: got v=%b w=%b d=%0d want v=1 w=1 d=0", wb_valid, wb_wen, wb_dest);
        end
    endtask

    task automatic test_back_to_back();
        logic [REG_W-1:0] exp_wb [3];
        int               nstall = 0;
        exp_wb[0] = 5'd1;
        exp_wb[1] = 5'd2;
        exp_wb[2] = 5'd3;
        idle_cycles(DEPTH);
        for (int k = 1; k <= 3; k++) begin
            drive_cycle(1'b1, REG_W'(k), 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (pending_cnt !== CNT_W'(k)) begin failures++; $display("[TB] FAIL b2b_pending k=%0d: got %0d want %0d", k, pending_cnt, k); end
        end
        checks++;
        if (wb_dest !== exp_wb[0] || wb_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_wb0: got v=%b d=%0d want v=1 d=1", wb_valid, wb_dest); end
        for (int k = 1; k < 4; k++) begin
            drive_cycle(1'b1, 5'd10, 1'b1, 5'd2, 1'b1, '0, 1'b0, 1'b0);
            if (obs_stall === 1'b1) nstall++;
            checks++;
            if (obs_stall !== exp_stall) begin failures++; $display("[TB] FAIL b2b_stall k=%0d: got %b want %b", k, obs_stall, exp_stall); end
            checks++;
            if (pending_cnt !== CNT_W'(m_pending())) begin failures++; $display("[TB] FAIL b2b_pend_model k=%0d: got %0d want %0d", k, pending_cnt, m_pending()); end
            if (k < 3) begin
                checks++;
                if (wb_dest !== exp_wb[k] || wb_valid !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL b2b_wb%0d: got v=%b d=%0d want v=1 d=%0d", k, wb_valid, wb_dest, exp_wb[k]);
                end
            end
        end
        checks++;
        if (nstall != 2) begin failures++; $display("[TB] FAIL b2b_stall_cycles: got %0d want 2", nstall); end
    endtask

    task automatic test_flush();
        bit saw6 = 1'b0;
        idle_cycles(DEPTH);
        drive_cycle(1'b1, 5'd4, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd6, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        idle_cycles(1);
        checks++;
        if (wb_valid !== 1'b1 || wb_wen !== 1'b1 || wb_dest !== 5'd4) begin
            failures++;
            $display("[TB] FAIL flush_wb4: got v=%b w=%b d=%0d want v=1 w=1 d=4", wb_valid, wb_wen, wb_dest);
        end
        drive_cycle(1'b1, 5'd8, 1'b1, 5'd6, 1'b1, '0, 1'b0, 1'b1);
        checks++;
        if (obs_stall !== 1'b1) begin failures++; $display("[TB] FAIL flush_prestall: got %b want 1", obs_stall); end
        checks++;
        if (wb_valid !== 1'b0 || pending_cnt !== '0) begin
            failures++;
            $display("[TB] FAIL flush_cleared: got v=%b p=%0d want v=0 p=0", wb_valid, pending_cnt);
        end
        drive_cycle(1'b1, 5'd13, 1'b1, 5'd6, 1'b1, '0, 1'b0, 1'b0);
        checks++;
        if (obs_stall !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy6: got %b want 0", obs_stall); end
        for (int c = 0; c < DEPTH; c++) begin
            idle_cycles(1);
            if (wb_valid === 1'b1 && wb_dest === 5'd6) saw6 = 1'b1;
            checks++;
            if (wb_valid !== m_wb_valid() || (m_wb_valid() && wb_dest !== m_wb_dest())) begin
                failures++;
                $display("[TB] FAIL flush_wb_model c=%0d: got v=%b d=%0d want v=%b d=%0d", c, wb_valid, wb_dest, m_wb_valid(), m_wb_dest());
            end
        end
        checks++;
        if (saw6) begin failures++; $display("[TB] FAIL flush_squash6: got wb of 6 want none"); end
    endtask

    task automatic test_async_reset();
        idle_cycles(DEPTH);
        drive_cycle(1'b1, 5'd11, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd12, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd13, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (pending_cnt !== CNT_W'(3)) begin failures++; $display("[TB] FAIL areset_pre_pending: got %0d want 3", pending_cnt); end
        issue_valid = 1'b1;
        issue_wen   = 1'b0;
        rs_addr     = 5'd12;
        rs_used     = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre_stall: got %b want 1", stall); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || pending_cnt !== '0) begin
            failures++;
            $display("[TB] FAIL areset_immediate: got v=%b p=%0d want v=0 p=0", wb_valid, pending_cnt);
        end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("[TB] FAIL areset_stall_low: got %b want 0", stall); end
        inflight.delete();
        rst_n = 1'b1;
        drive_cycle(1'b1, 5'd14, 1'b1, 5'd12, 1'b1, '0, 1'b0, 1'b0);
        checks++;
        if (obs_stall !== 1'b0) begin failures++; $display("[TB] FAIL areset_stall_after: got %b want 0", obs_stall); end
        checks++;
        if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL areset_no_wb: got %b want 0", wb_valid); end
    endtask

    task automatic test_random();
        logic             iv, w, rsu, rtu, fl;
        logic [REG_W-1:0] d, rs, rt;
        for (int c = 0; c < 400; c++) begin
            iv  = ($urandom_range(0, 3) != 0);
            w   = ($urandom_range(0, 4) != 0);
            d   = REG_W'($urandom_range(0, 7));
            rs  = REG_W'($urandom_range(0, 7));
            rt  = REG_W'($urandom_range(0, 7));
            rsu = ($urandom_range(0, 1) != 0);
            rtu = ($urandom_range(0, 2) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            drive_cycle(iv, d, w, rs, rsu, rt, rtu, fl);
            checks++;
            if (obs_stall !== exp_stall) begin failures++; $display("[TB] FAIL rand_stall c=%0d: got %b want %b", c, obs_stall, exp_stall); end
            checks++;
            if (wb_valid !== m_wb_valid() || wb_wen !== m_wb_wen()) begin
                failures++;
                $display("[TB] FAIL rand_wb c=%0d: got v=%b w=%b want v=%b w=%b", c, wb_valid, wb_wen, m_wb_valid(), m_wb_wen());
            end
            if (m_wb_valid()) begin
                checks++;
                if (wb_dest !== m_wb_dest()) begin failures++; $display("[TB] FAIL rand_wb_dest c=%0d: got %0d want %0d", c, wb_dest, m_wb_dest()); end
            end
            checks++;
            if (pending_cnt !== CNT_W'(m_pending())) begin
                failures++;
                $display("[TB] FAIL rand_pending c=%0d: got %0d want %0d", c, pending_cnt, m_pending());
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_raw_hazard();
        test_reg_zero();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion want finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
